// File: rtl/rename_regfile_pkg.sv
// Shared sizes and the per-register rename entry for the rename register file.
package rename_regfile_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_TAG_W = 4;
  localparam int XLEN      = 32;
  localparam int NUM_RD    = 3;
  localparam int COMMIT_W  = 2;

  typedef struct packed {
    logic                 busy;
    logic [ROB_TAG_W-1:0] tag;
  } rn_ent_t;
endpackage

// File: rtl/rename_regfile_rdport.sv
// One decode read port: x0 forcing plus the commit-to-read bypass.
// RENAME_REGFILE_BYPASS_EN selects the bypass; otherwise only registered state is returned.
module rename_regfile_rdport
  import rename_regfile_pkg::*;
(
  input  logic [REG_IDX_W-1:0]                i_idx,
  input  logic [XLEN-1:0]                     i_val,
  input  logic                                i_busy,
  input  logic [ROB_TAG_W-1:0]                i_tag,
  input  logic [COMMIT_W-1:0]                 i_cm_valid,
  input  logic [COMMIT_W-1:0][REG_IDX_W-1:0]  i_cm_rd,
  input  logic [COMMIT_W-1:0][XLEN-1:0]       i_cm_value,
  input  logic [COMMIT_W-1:0][ROB_TAG_W-1:0]  i_cm_tag,
  output logic [XLEN-1:0]                     o_value,
  output logic                                o_busy,
  output logic [ROB_TAG_W-1:0]                o_tag
);
`ifndef RENAME_REGFILE_BYPASS_EN
  logic w_unused;
  assign w_unused = ^{i_cm_valid, i_cm_rd, i_cm_value, i_cm_tag};
`endif

  always_comb begin
    o_value = i_val;
    o_busy  = i_busy;
    o_tag   = i_tag;
`ifdef RENAME_REGFILE_BYPASS_EN
    // later (younger) ports overwrite earlier matches
    for (int k = 0; k < COMMIT_W; k++) begin
      if (i_cm_valid[k] && i_cm_rd[k] == i_idx) begin
        o_value = i_cm_value[k];
        o_busy  = i_busy && (i_tag != i_cm_tag[k]);
      end
    end
`endif
    if (i_idx == '0) begin
      o_value = '0;
      o_busy  = 1'b0;
      o_tag   = '0;
    end
  end
endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tag (busy + ROB tag).
// Build option: RENAME_REGFILE_BYPASS_EN enables same-cycle commit bypass on reads.
module rename_regfile
  import rename_regfile_pkg::*;
(
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush_in,
  input  logic [COMMIT_W-1:0]             cm_valid,
  input  logic [COMMIT_W*REG_IDX_W-1:0]   cm_rd,
  input  logic [COMMIT_W*XLEN-1:0]        cm_value,
  input  logic [COMMIT_W*ROB_TAG_W-1:0]   cm_tag,
  input  logic                            rn_valid,
  input  logic [REG_IDX_W-1:0]            rn_rd,
  input  logic [ROB_TAG_W-1:0]            rn_tag,
  input  logic [NUM_RD*REG_IDX_W-1:0]     rd_idx,
  output logic [NUM_RD*XLEN-1:0]          rd_value,
  output logic [NUM_RD-1:0]               rd_busy,
  output logic [NUM_RD*ROB_TAG_W-1:0]     rd_tag
);
  logic    [REG_NUM-1:0][XLEN-1:0]       r_val, w_val_n;
  rn_ent_t [REG_NUM-1:0]                 r_ent, w_ent_n;
  logic    [REG_NUM-1:0]                 w_clr;
  logic    [COMMIT_W-1:0][REG_IDX_W-1:0] w_cm_rd;
  logic    [COMMIT_W-1:0][XLEN-1:0]      w_cm_val;
  logic    [COMMIT_W-1:0][ROB_TAG_W-1:0] w_cm_tag;

  assign w_cm_rd  = cm_rd;
  assign w_cm_val = cm_value;
  assign w_cm_tag = cm_tag;

  always_comb begin
    w_val_n = r_val;
    w_ent_n = r_ent;
    w_clr   = '0;
    // younger commits overwrite both the value and the busy-clear decision
    for (int k = 0; k < COMMIT_W; k++) begin
      if (cm_valid[k] && w_cm_rd[k] != '0) begin
        w_val_n[w_cm_rd[k]] = w_cm_val[k];
        w_clr[w_cm_rd[k]]   = r_ent[w_cm_rd[k]].busy && (r_ent[w_cm_rd[k]].tag == w_cm_tag[k]);
      end
    end
    for (int i = 0; i < REG_NUM; i++)
      if (w_clr[i] || flush_in) w_ent_n[i].busy = 1'b0;
    if (!flush_in && rn_valid && rn_rd != '0) begin
      w_ent_n[rn_rd].busy = 1'b1;
      w_ent_n[rn_rd].tag  = rn_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_val <= '0;
      r_ent <= '0;
    end else if (rdy_in) begin
      r_val <= w_val_n;
      r_ent <= w_ent_n;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_IDX_W-1:0] w_idx;
    assign w_idx = rd_idx[p*REG_IDX_W +: REG_IDX_W];
    rename_regfile_rdport u_rd (
      .i_idx      (w_idx),
      .i_val      (r_val[w_idx]),
      .i_busy     (r_ent[w_idx].busy),
      .i_tag      (r_ent[w_idx].tag),
      .i_cm_valid (cm_valid),
      .i_cm_rd    (w_cm_rd),
      .i_cm_value (w_cm_val),
      .i_cm_tag   (w_cm_tag),
      .o_value    (rd_value[p*XLEN +: XLEN]),
      .o_busy     (rd_busy[p]),
      .o_tag      (rd_tag[p*ROB_TAG_W +: ROB_TAG_W])
    );
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed scenarios plus random traffic vs a reference model.
module tb_rename_regfile;
  import rename_regfile_pkg::*;

  logic                          clk_in = 1'b0;
  logic                          rst_in, rdy_in, flush_in;
  logic [COMMIT_W-1:0]           cm_valid;
  logic [COMMIT_W*REG_IDX_W-1:0] cm_rd;
  logic [COMMIT_W*XLEN-1:0]      cm_value;
  logic [COMMIT_W*ROB_TAG_W-1:0] cm_tag;
  logic                          rn_valid;
  logic [REG_IDX_W-1:0]          rn_rd;
  logic [ROB_TAG_W-1:0]          rn_tag;
  logic [NUM_RD*REG_IDX_W-1:0]   rd_idx;
  logic [NUM_RD*XLEN-1:0]        rd_value;
  logic [NUM_RD-1:0]             rd_busy;
  logic [NUM_RD*ROB_TAG_W-1:0]   rd_tag;

  rename_regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value), .cm_tag(cm_tag),
    .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_tag(rn_tag),
    .rd_idx(rd_idx), .rd_value(rd_value), .rd_busy(rd_busy), .rd_tag(rd_tag)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // reference state: one value/busy/tag per architectural register
  logic [XLEN-1:0]      m_val [REG_NUM];
  logic                 m_busy[REG_NUM];
  logic [ROB_TAG_W-1:0] m_tag [REG_NUM];

  typedef struct {
    logic [XLEN-1:0]      v[NUM_RD];
    logic                 b[NUM_RD];
    logic [ROB_TAG_W-1:0] t[NUM_RD];
  } exp_t;
  exp_t q[$];

  function automatic int crd(int k);
    return int'(cm_rd[k*REG_IDX_W +: REG_IDX_W]);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    for (int p = 0; p < NUM_RD; p++) begin
      int r;
      r = int'(rd_idx[p*REG_IDX_W +: REG_IDX_W]);
      e.v[p] = m_val[r];
      e.b[p] = m_busy[r];
      e.t[p] = m_tag[r];
`ifdef RENAME_REGFILE_BYPASS_EN
      for (int k = 0; k < COMMIT_W; k++) begin
        if (cm_valid[k] && crd(k) == r) begin
          e.v[p] = cm_value[k*XLEN +: XLEN];
          e.b[p] = m_busy[r] && (m_tag[r] != cm_tag[k*ROB_TAG_W +: ROB_TAG_W]);
        end
      end
`endif
      if (r == 0) begin
        e.v[p] = '0;
        e.b[p] = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic model_update();
    logic [XLEN-1:0]      nv[REG_NUM];
    logic                 nb[REG_NUM];
    logic [ROB_TAG_W-1:0] nt[REG_NUM];
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      nv = m_val; nb = m_busy; nt = m_tag;
      for (int k = 0; k < COMMIT_W; k++) begin
        int r;
        r = crd(k);
        if (cm_valid[k] && r != 0) begin
          nv[r] = cm_value[k*XLEN +: XLEN];
          nb[r] = (m_busy[r] && m_tag[r] == cm_tag[k*ROB_TAG_W +: ROB_TAG_W]) ? 1'b0 : m_busy[r];
        end
      end
      if (flush_in) begin
        for (int i = 0; i < REG_NUM; i++) nb[i] = 1'b0;
      end else if (rn_valid && rn_rd != 0) begin
        nb[rn_rd] = 1'b1;
        nt[rn_rd] = rn_tag;
      end
      m_val = nv; m_busy = nb; m_tag = nt;
    end
  endtask

  // inputs are already driven; queue the expected reads, then advance one edge
  task automatic tick();
    if (!rst_in) q.push_back(predict());
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int p = 0; p < NUM_RD; p++) begin
        chk($sformatf("sb_val%0d", p), rd_value[p*XLEN +: XLEN], e.v[p]);
        chk($sformatf("sb_busy%0d", p), 32'(rd_busy[p]), 32'(e.b[p]));
        if (e.b[p]) chk($sformatf("sb_tag%0d", p), 32'(rd_tag[p*ROB_TAG_W +: ROB_TAG_W]), 32'(e.t[p]));
      end
    end
  end

  task automatic clr_in();
    flush_in = 0; cm_valid = '0; cm_rd = '0; cm_value = '0; cm_tag = '0;
    rn_valid = 0; rn_rd = '0; rn_tag = '0; rdy_in = 1;
  endtask

  task automatic set_cm(int k, int rd, logic [31:0] v, int tg);
    cm_valid[k] = 1'b1;
    cm_rd[k*REG_IDX_W +: REG_IDX_W]    = REG_IDX_W'(rd);
    cm_value[k*XLEN +: XLEN]           = v;
    cm_tag[k*ROB_TAG_W +: ROB_TAG_W]   = ROB_TAG_W'(tg);
  endtask

  task automatic set_rn(int rd, int tg);
    rn_valid = 1; rn_rd = REG_IDX_W'(rd); rn_tag = ROB_TAG_W'(tg);
  endtask

  task automatic set_rd(int a, int b, int c);
    rd_idx = {REG_IDX_W'(c), REG_IDX_W'(b), REG_IDX_W'(a)};
  endtask

  function automatic logic [31:0] val(int p);
    return rd_value[p*XLEN +: XLEN];
  endfunction

  initial begin
    clr_in();
    set_rd(5, 5, 5);
    rst_in = 1;
    repeat (3) tick();
    rst_in = 0;
    #1;
    chk("rst_val", val(0), 32'h0);
    chk("rst_busy", 32'(rd_busy[0]), 32'h0);
    chk("rst_tag", 32'(rd_tag[3:0]), 32'h0);

    // rename x5 -> 3, then commit x5 with tag 3
    set_rn(5, 3); tick();
    clr_in(); set_rd(5, 0, 5); #1;
    chk("x5_busy", 32'(rd_busy[0]), 32'h1);
    chk("x5_tag", 32'(rd_tag[3:0]), 32'h3);
    set_cm(0, 5, 32'hDEAD, 3); #1;
`ifdef RENAME_REGFILE_BYPASS_EN
    chk("x5_byp_val", val(2), 32'hDEAD);
    chk("x5_byp_busy", 32'(rd_busy[2]), 32'h0);
`else
    chk("x5_nobyp_val", val(2), 32'h0);
    chk("x5_nobyp_busy", 32'(rd_busy[2]), 32'h1);
`endif
    tick(); clr_in(); #1;
    chk("x5_val", val(0), 32'hDEAD);
    chk("x5_busy_after", 32'(rd_busy[0]), 32'h0);

    // stale commit tag must not clear a newer rename
    set_rn(7, 2); tick();
    clr_in(); set_rn(7, 6); tick();
    clr_in(); set_cm(1, 7, 32'h77, 2); tick();
    clr_in(); set_rd(0, 7, 0); #1;
    chk("x7_val", val(1), 32'h77);
    chk("x7_busy", 32'(rd_busy[1]), 32'h1);
    chk("x7_tag", 32'(rd_tag[7:4]), 32'h6);

    // rename beats same-cycle commit clear
    set_rn(9, 4); tick();
    clr_in(); set_cm(0, 9, 32'h99, 4); set_rn(9, 8); tick();
    clr_in(); set_rd(9, 0, 0); #1;
    chk("x9_val", val(0), 32'h99);
    chk("x9_busy", 32'(rd_busy[0]), 32'h1);
    chk("x9_tag", 32'(rd_tag[3:0]), 32'h8);

    // two commits to the same register: younger wins
    set_rn(10, 2); tick();
    clr_in(); set_cm(0, 10, 32'h11, 1); set_cm(1, 10, 32'h22, 2); tick();
    clr_in(); set_rd(0, 0, 10); #1;
    chk("x10_val", val(2), 32'h22);
    chk("x10_busy", 32'(rd_busy[2]), 32'h0);

    // flush with commit; rename in the flush cycle dropped
    set_rn(3, 5); tick();
    clr_in(); flush_in = 1; set_cm(0, 4, 32'h44, 9); set_rn(6, 1); tick();
    clr_in(); set_rd(3, 4, 6); #1;
    chk("fl_x3_busy", 32'(rd_busy[0]), 32'h0);
    chk("fl_x3_val", val(0), 32'h0);
    chk("fl_x4_val", val(1), 32'h44);
    chk("fl_x6_busy", 32'(rd_busy[2]), 32'h0);
    chk("fl_x7_busy", 32'(dut.r_ent[7].busy), 32'h0);

    // x0 ignores commit and rename
    set_cm(1, 0, 32'h55, 7); set_rn(0, 7); tick();
    clr_in(); set_rd(0, 0, 0); #1;
    chk("x0_val", val(0), 32'h0);
    chk("x0_busy", 32'(rd_busy[0]), 32'h0);

    // stall holds all state
    rdy_in = 0; set_cm(0, 12, 32'h12, 3); set_rn(12, 3); tick();
    clr_in(); set_rd(12, 0, 0); #1;
    chk("stall_val", val(0), 32'h0);
    chk("stall_busy", 32'(rd_busy[0]), 32'h0);

    // random traffic on a small register window to force collisions
    for (int it = 0; it < 600; it++) begin
      rst_in   = ($urandom_range(0, 149) == 0);
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush_in = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < COMMIT_W; k++) begin
        int r;
        r = $urandom_range(0, 7);
        cm_valid[k] = $urandom_range(0, 1);
        cm_rd[k*REG_IDX_W +: REG_IDX_W]  = REG_IDX_W'(r);
        cm_value[k*XLEN +: XLEN]         = $urandom;
        cm_tag[k*ROB_TAG_W +: ROB_TAG_W] = $urandom_range(0, 1) ? m_tag[r] : ROB_TAG_W'($urandom);
      end
      rn_valid = $urandom_range(0, 1);
      rn_rd    = REG_IDX_W'($urandom_range(0, 7));
      rn_tag   = ROB_TAG_W'($urandom);
      set_rd($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
      tick();
    end

    rst_in = 0;
    clr_in();
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk_in);
    #1;
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Architectural register file with a per-register rename tag (ROB index plus busy bit) for the out-of-order RISC-V core.
- Sits between decode/dispatch and the ROB.
- Decode reads source operands and tags over NUM_RD read ports and renames one destination per cycle. The ROB retires up to COMMIT_W results per cycle.
- Mispredict flush clears all rename state. Architectural values are kept.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 hardwired to zero.
- REG_IDX_W, 5, log2(REG_NUM).
- ROB_TAG_W, 4, ROB index width.
- XLEN, 32, data width.
- NUM_RD, 3, decode read ports (rs1, rs2, plus the jalr port used by IF).
- COMMIT_W, 2, commit ports per cycle; higher index means younger instruction.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global stall; when low, all state holds.
- flush_in  in  1  mispredict flush from the ROB.
- cm_valid  in  COMMIT_W  per-port commit valid.
- cm_rd  in  COMMIT_W*REG_IDX_W  commit destination registers.
- cm_value  in  COMMIT_W*XLEN  commit values.
- cm_tag  in  COMMIT_W*ROB_TAG_W  ROB tag of each committing instruction.
- rn_valid  in  1  rename request from dispatch.
- rn_rd  in  REG_IDX_W  destination to rename.
- rn_tag  in  ROB_TAG_W  ROB tag allocated to rn_rd.
- rd_idx  in  NUM_RD*REG_IDX_W  read indices (combinational).
- rd_value  out  NUM_RD*XLEN  operand values.
- rd_busy  out  NUM_RD  operand still pending in the ROB.
- rd_tag  out  NUM_RD*ROB_TAG_W  producing ROB tag; valid only when the matching rd_busy is 1.

Behaviour:
- State per register: value[XLEN], busy, tag.
- Reset (rst_in=1 at a clock edge):
  - all values become 0;
  - all busy bits become 0;
  - all tags become 0.
- Read outputs are combinational. After reset they return value 0, busy 0, tag 0.
- rdy_in=0: no state update. Read outputs still reflect the current state plus same-cycle bypass.
- Read path, per port p, for register r = rd_idx[p]:
  - r==0: rd_value=0, rd_busy=0.
  - Otherwise, the youngest valid commit port k with cm_rd[k]==r bypasses its value: rd_value=cm_value[k].
  - If there is such a k and busy[r] && tag[r]==cm_tag[k], then rd_busy=0.
  - Otherwise rd_busy=busy[r] and rd_tag=tag[r].
  - The same-cycle rename (rn_*) is NOT visible on the read ports. Sources of the instruction being renamed see the pre-rename state.
- Commit update, at the edge with rdy_in=1 and flush_in=0, ports processed oldest to youngest:
  - value[cm_rd] <= cm_value, ignored when cm_rd==0;
  - if busy && tag==cm_tag, busy <= 0.
  - Two commits to the same rd in one cycle: the younger value and the younger tag comparison win.
- Rename update: when rn_valid && rn_rd!=0, busy[rn_rd] <= 1 and tag[rn_rd] <= rn_tag.
  - Rename has priority over a same-cycle commit clear on the same register.
  - The commit value is still written.
- Flush (flush_in=1 with rdy_in=1):
  - all busy bits <= 0;
  - same-cycle commits still write their values, because the flushing instruction's own commit must land;
  - same-cycle rename is dropped.
- Reset mid-operation overrides flush, commit and rename.
- x0 is never busy and never written.

Optional Feature:
- Macro: RENAME_REGFILE_BYPASS_EN.
- Defined: the commit-to-read bypass described above is present.
- Undefined: read ports return registered state only (rd_value=value[r], rd_busy=busy[r]). This shortens the read path. Dispatch must then tolerate a one-cycle-stale busy bit; the ROB broadcast covers this.

Decomposition:
- Shared package constants: REG_NUM, REG_IDX_W, ROB_TAG_W, XLEN, and a struct/typedef for {busy, tag}.
- One sub-module: rename_regfile_rdport. It is instantiated NUM_RD times and contains the per-port bypass/priority mux.

Test Plan:
- Reset, then read x5 -> rd_value=0, rd_busy=0.
- Rename x5 with tag 3. Next cycle read x5 -> busy=1, tag=3. Then commit x5=0xDEAD with tag 3. Same cycle -> rd_value=0xDEAD and busy=0 with bypass on. After the edge -> busy=0, value 0xDEAD.
- Rename x7 to tag 2, then to tag 6. Commit x7 with tag 2 -> value updated, busy stays 1, tag=6.
- Same cycle: commit x9 tag 4 (busy tag 4) and rename x9 tag 8 -> after the edge busy=1, tag=8, value=commit value.
- Two commits to x10 (port0=0x11 tag 1, port1=0x22 tag 2; busy tag 2) -> value 0x22, busy=0.
- Rename x3 tag 5, then flush with a simultaneous commit x4=0x44 -> all busy=0, x4=0x44, x3 value unchanged. Writes to x0 -> x0 reads 0.
